// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debounce bank: per-channel FSM
// state encoding and the counter-width helper used to size timers.
package debounce_pkg;

  // Per-channel debounce state: accepting changes, or locked out after one.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_LOCK   = 1'b1
  } state_e;

  // Ceil-log2 with a floor of 1 bit, so a counter that must hold 0..N
  // (sized as clog2_min1(N+1)) never collapses to zero width when N is 0 or 1.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Button-side bundle of the debounce bank: tick enable and raw pins in,
// debounced level and event pulses out, one bit per channel.
interface debounce_bank_if #(
  parameter int N_CH = 4
) ();

  logic            i_tick;
  logic [N_CH-1:0] i_btn;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_long;

  // Master drives pins and tick, observes debounced results.
  modport master (
    output i_tick, i_btn,
    input  o_level, o_rise, o_fall, o_long
  );

  // Slave is the debounce bank itself.
  modport slave (
    input  i_tick, i_btn,
    output o_level, o_rise, o_fall, o_long
  );

endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: optional pin inversion, two-flop synchroniser,
// accept-then-lockout FSM with tick-gated timer, one-cycle rise/fall pulses
// and a one-shot long-press pulse.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int HOLD_TICKS = 163,
  parameter int LONG_TICKS = 4096,
  parameter bit INVERT     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);

  localparam int TW = clog2_min1(HOLD_TICKS + 1);
  localparam int LW = clog2_min1(LONG_TICKS + 1);

  localparam bit HOLD_EN = (HOLD_TICKS > 0);
  localparam bit LONG_EN = (LONG_TICKS > 0);

  localparam logic [TW-1:0] HOLD_VAL  = TW'(HOLD_TICKS);
  localparam logic [LW-1:0] LONG_VAL  = LW'(LONG_TICKS);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_EN ? LONG_TICKS - 1 : 0);

  logic          r_sync0;
  logic          r_sync1;
  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [LW-1:0] r_cnt;
  logic          r_fired;
  logic          r_long;

  logic          w_pin;
  logic          w_accept;

  // Normalise polarity before synchronising so the FSM only sees active-high.
  assign w_pin    = i_btn ^ INVERT;
  // A change is taken only while not locked out.
  assign w_accept = (r_state == ST_STABLE) && (r_sync1 != r_level);

  // Two-flop synchroniser; runs every clock regardless of the tick enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync1 take the old sync0; blocking
      // ones would collapse the two stages into a single flop.
      r_sync0 <= w_pin;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce FSM: accept a change, pulse it, then ignore the pin for the lockout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_STABLE;
      r_timer <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // NOTE: pulses default low every clock so any set below lasts exactly one cycle.
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_accept) begin
            r_level <= r_sync1;
            r_rise  <= r_sync1;
            r_fall  <= ~r_sync1;
            if (HOLD_EN) begin
              r_timer <= HOLD_VAL;
              r_state <= ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (i_tick) begin
            // Leave lockout on the tick that brings the timer to zero; clamp
            // so the timer can never wrap.
            if (r_timer <= TW'(1)) begin
              r_timer <= '0;
              r_state <= ST_STABLE;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
        end
        default: r_state <= ST_STABLE;
      endcase
    end
  end

  // Long-press counter: restart on each accepted press, fire once when it reaches LONG_TICKS.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_fired <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_accept && r_sync1) begin
        r_cnt   <= '0;
        r_fired <= 1'b0;
      end else if (w_accept) begin
        // Release: arm for the next press; a partial count is simply abandoned.
        r_fired <= 1'b0;
      end else if (LONG_EN && r_level && !r_fired && i_tick) begin
        if (r_cnt == LONG_LAST) begin
          r_cnt   <= LONG_VAL;
          r_fired <= 1'b1;
          r_long  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + LW'(1);
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_long  = r_long;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels for the clock's user buttons.
// All channels share the clock, reset and timer tick; each has its own
// polarity bit and reports events in the same cycle as its neighbours.
module debounce_bank #(
  parameter int              N_CH       = 4,
  parameter int              HOLD_TICKS = 163,
  parameter int              LONG_TICKS = 4096,
  parameter logic [N_CH-1:0] INVERT     = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  debounce_bank_if.slave  bus
);

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_long;

  // One channel instance per button pin.
  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    debounce_chan #(
      .HOLD_TICKS (HOLD_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .INVERT     (INVERT[k])
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_tick  (bus.i_tick),
      .i_btn   (bus.i_btn[k]),
      .o_level (w_level[k]),
      .o_rise  (w_rise[k]),
      .o_fall  (w_fall[k]),
      .o_long  (w_long[k])
    );
  end

  assign bus.o_level = w_level;
  assign bus.o_rise  = w_rise;
  assign bus.o_fall  = w_fall;
  assign bus.o_long  = w_long;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank. Two instances with different
// parameters: dut_a (HOLD 163, long-press disabled, no inversion) and
// dut_b (HOLD 10, LONG 20, ch1 active-low).
module tb_debounce_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debounce_bank_if #(.N_CH(4)) bus_a ();
  debounce_bank_if #(.N_CH(4)) bus_b ();

  debounce_bank #(
    .N_CH(4), .HOLD_TICKS(163), .LONG_TICKS(0), .INVERT(4'b0000)
  ) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  debounce_bank #(
    .N_CH(4), .HOLD_TICKS(10), .LONG_TICKS(20), .INVERT(4'b0010)
  ) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  typedef struct packed {
    logic [3:0] btn_a;
    logic [3:0] btn_b;
    logic [3:0] lvl_a;
    logic [3:0] rise_a;
    logic [3:0] fall_a;
    logic [3:0] long_a;
    logic [3:0] lvl_b;
    logic [3:0] rise_b;
    logic [3:0] fall_b;
    logic [3:0] long_b;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl_rst[5];
  vec_t tbl_inv[5];
  vec_t tbl_rel[4];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    check({tag, " lvl_a"},  32'(bus_a.o_level), 32'(e.lvl_a));
    check({tag, " rise_a"}, 32'(bus_a.o_rise),  32'(e.rise_a));
    check({tag, " fall_a"}, 32'(bus_a.o_fall),  32'(e.fall_a));
    check({tag, " long_a"}, 32'(bus_a.o_long),  32'(e.long_a));
    check({tag, " lvl_b"},  32'(bus_b.o_level), 32'(e.lvl_b));
    check({tag, " rise_b"}, 32'(bus_b.o_rise),  32'(e.rise_b));
    check({tag, " fall_b"}, 32'(bus_b.o_fall),  32'(e.fall_b));
    check({tag, " long_b"}, 32'(bus_b.o_long),  32'(e.long_b));
  endtask

  // Drive one vector, queue its expectation, pop and compare after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    vec_t e;
    bus_a.i_btn = v.btn_a;
    bus_b.i_btn = v.btn_b;
    exp_q.push_back(v);
    step();
    e = exp_q.pop_front();
    check_outs(tag, e);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t zero;
    int t_r, t_f, t_l, nr, nf, nl, glitch;
    logic [3:0] l_val, f_val;
    bit found;

    // btn_a btn_b | lvl_a rise_a fall_a long_a | lvl_b rise_b fall_b long_b
    tbl_rst[0] = '{4'hF, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_rst[1] = '{4'hF, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_rst[2] = '{4'hF, 4'h2, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_rst[3] = '{4'hF, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_rst[4] = '{4'hF, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    tbl_inv[0] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_inv[1] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_inv[2] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_inv[3] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0};
    tbl_inv[4] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0};

    tbl_rel[0] = '{4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_rel[1] = '{4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl_rel[2] = '{4'h2, 4'h8, 4'h2, 4'h2, 4'h0, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0};
    tbl_rel[3] = '{4'h2, 4'h8, 4'h2, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0};

    zero = '0;

    // ---------------- reset with pins already pressed ----------------
    bus_a.i_tick = 1'b1;
    bus_b.i_tick = 1'b1;
    bus_a.i_btn  = 4'hF;
    bus_b.i_btn  = 4'h2;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_outs("in_reset", zero);
    rst = 1'b0;
    t_r = 0;
    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("rst_row%0d", i), tbl_rst[i]);
      if (bus_a.o_rise != 4'h0) t_r = cyc;
    end

    // ---------------- dut_a: lockout length, no long pulse ----------------
    bus_a.i_btn = 4'h0;
    nf = 0; nl = 0; t_f = 0; f_val = '0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bus_a.o_fall != 4'h0) begin
        if (nf == 0) begin
          t_f   = cyc;
          f_val = bus_a.o_fall;
        end
        nf++;
      end
      if (bus_a.o_long != 4'h0) nl++;
    end
    check("lock_fall_count", 32'(nf), 32'd1);
    check("lock_fall_value", 32'(f_val), 32'hF);
    check("lock_fall_gap", 32'(t_f - t_r), 32'd164);
    check("long_disabled", 32'(nl), 32'd0);

    // ---------------- dut_a: bouncing ch0 ----------------
    nr = 0; nf = 0; glitch = 0; t_r = 0; t_f = 0;
    for (int i = 0; i < 300; i++) begin
      if (i < 100)      bus_a.i_btn = {3'b000, ((i / 5) % 2) == 0};
      else if (i < 200) bus_a.i_btn = 4'b0001;
      else              bus_a.i_btn = 4'b0000;
      step();
      if (bus_a.o_rise[0]) begin nr++; t_r = cyc; end
      if (bus_a.o_fall[0]) begin nf++; t_f = cyc; end
      if (nr == 1 && nf == 0 && !bus_a.o_level[0]) glitch++;
    end
    check("bounce_rise_count", 32'(nr), 32'd1);
    check("bounce_level_held", 32'(glitch), 32'd0);
    check("bounce_fall_count", 32'(nf), 32'd1);
    check("bounce_fall_late", 32'(t_f - t_r >= 163), 32'd1);

    // ---------------- dut_b: tick-gated lockout ----------------
    bus_b.i_btn = 4'b0011;
    nr = 0; nf = 0; nl = 0; t_r = 0; t_f = 0;
    for (int i = 0; i < 100; i++) begin
      bus_b.i_tick = ((cyc + 1) % 4) == 0;
      if (nr > 0) bus_b.i_btn = 4'b0010;
      step();
      if (bus_b.o_rise[0]) begin nr++; t_r = cyc; end
      if (bus_b.o_fall[0]) begin nf++; t_f = cyc; end
      if (bus_b.o_long != 4'h0) nl++;
    end
    bus_b.i_tick = 1'b1;
    check("tick_rise_count", 32'(nr), 32'd1);
    check("tick_fall_count", 32'(nf), 32'd1);
    check("tick_fall_gap", 32'((t_f - t_r >= 38) && (t_f - t_r <= 41)), 32'd1);
    check("tick_no_long", 32'(nl), 32'd0);
    repeat (20) step();

    // ---------------- dut_b: long press on ch2 held 50 ticks ----------------
    bus_b.i_btn = 4'b0110;
    nr = 0; nf = 0; nl = 0; t_r = 0; t_l = 0; l_val = '0;
    for (int i = 0; i < 80; i++) begin
      if (nr > 0 && (cyc - t_r) >= 50) bus_b.i_btn = 4'b0010;
      step();
      if (bus_b.o_rise[2]) begin nr++; t_r = cyc; end
      if (bus_b.o_fall[2]) nf++;
      if (bus_b.o_long != 4'h0) begin
        nl++;
        t_l   = cyc;
        l_val = bus_b.o_long;
      end
    end
    check("long_rise_count", 32'(nr), 32'd1);
    check("long_count", 32'(nl), 32'd1);
    check("long_delay", 32'(t_l - t_r), 32'd20);
    check("long_value", 32'(l_val), 32'h4);
    check("long_fall_count", 32'(nf), 32'd1);

    // ---------------- dut_b: short press on ch2, no long pulse ----------------
    bus_b.i_btn = 4'b0110;
    nr = 0; nf = 0; nl = 0; t_r = 0;
    for (int i = 0; i < 60; i++) begin
      if (nr > 0 && (cyc - t_r) >= 15) bus_b.i_btn = 4'b0010;
      step();
      if (bus_b.o_rise[2]) begin nr++; t_r = cyc; end
      if (bus_b.o_fall[2]) nf++;
      if (bus_b.o_long != 4'h0) nl++;
    end
    check("short_rise_count", 32'(nr), 32'd1);
    check("short_fall_count", 32'(nf), 32'd1);
    check("short_no_long", 32'(nl), 32'd0);
    repeat (20) step();

    // ---------------- dut_b: inversion and simultaneous channels ----------------
    for (int i = 0; i < 5; i++) run_vec($sformatf("inv_row%0d", i), tbl_inv[i]);

    // ---------------- async reset in the middle of a lockout ----------------
    bus_a.i_btn = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (bus_a.o_rise[1]) found = 1'b1;
    end
    check("pre_reset_rise_seen", 32'(found), 32'd1);
    repeat (20) step();
    check("pre_reset_level_a", 32'(bus_a.o_level), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_reset", zero);
    @(negedge clk);
    check_outs("held_reset", zero);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) run_vec($sformatf("rel_row%0d", i), tbl_rel[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
